// File: rtl/roll_dice_multi.sv
// Multi-die roller: a synchronised button spins the dice, and they settle
// for a fixed number of cycles after release before the result is flagged.
module roll_dice_multi #(
    parameter int N_DICE     = 2,
    parameter int FACES      = 6,
    parameter int SETTLE_CYC = 4,
    localparam int DW = $clog2(FACES + 1),
    localparam int SW = $clog2(N_DICE * FACES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 button,
    output logic [N_DICE*DW-1:0] throw,
    output logic [SW-1:0]        sum,
    output logic                 valid,
    output logic                 rolling,
    output logic [7:0]           roll_count
);

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        SETTLE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       sync1;
    logic       btn_s;
    logic       adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= button;
            btn_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (btn_s) state_nx = ROLL;
            end
            ROLL: begin
                if (!btn_s) begin
                    state_nx = SETTLE;
                    cnt_nx   = 4'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (btn_s) begin
                    state_nx = ROLL;
                    cnt_nx   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign adv     = (state == ROLL) || (state == SETTLE);
    assign rolling = adv;
    assign valid   = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            roll_count <= 8'd0;
        end else if (valid && roll_count != 8'hFF) begin
            roll_count <= roll_count + 8'd1;
        end
    end

    // Each die steps by its own index+1 so the dice never move in lockstep.
    for (genvar i = 0; i < N_DICE; i++) begin : g_die
        logic [DW-1:0] die_q;
        logic [DW-1:0] die_nx;

        always_comb begin
            die_nx = die_q;
            if (die_q == '0 || die_q > DW'(FACES)) begin
                die_nx = DW'(1);
            end else if (adv) begin
                die_nx = DW'((int'(die_q) + i) % FACES + 1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                die_q <= DW'(1);
            end else begin
                die_q <= die_nx;
            end
        end

        assign throw[i*DW +: DW] = die_q;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_DICE; i++) begin
            sum = sum + SW'(throw[i*DW +: DW]);
        end
    end

endmodule

// File: doc/roll_dice_multi.md
ROLL_DICE_MULTI -- requirements
Module: roll_dice_multi

Interface
REQ-001 Parameter N_DICE, default 2, number of dice; legal range 1..8.
REQ-002 Parameter FACES, default 6, faces per die; legal range 2..15.
REQ-003 Parameter SETTLE_CYC, default 4, cycles dice keep rolling after release; legal range 1..15.
REQ-004 Localparams SHALL be DW = clog2(FACES+1) and SW = clog2(N_DICE*FACES+1).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low: rst=0 resets immediately, independent of clk.
REQ-007 button  input  1  asynchronous roll request; high = roll.
REQ-008 throw  output  N_DICE*DW  packed die values; die i occupies bits [i*DW +: DW].
REQ-009 sum  output  SW  arithmetic sum of all die values.
REQ-010 valid  output  1  one-cycle pulse marking a final result.
REQ-011 rolling  output  1  high while the FSM is in ROLL or SETTLE.
REQ-012 roll_count  output  8  number of completed rolls, saturating.

Function
REQ-013 button SHALL pass through a 2-flop synchroniser; btn_s denotes the synchronised value, and all timing below is relative to btn_s.
REQ-014 FSM states SHALL be IDLE, ROLL, SETTLE and DONE.
REQ-015 IDLE: dice hold; btn_s=1 -> ROLL.
REQ-016 ROLL: dice advance every cycle; btn_s=0 -> SETTLE, loading the settle counter with SETTLE_CYC-1.
REQ-017 SETTLE: dice advance every cycle; btn_s=1 -> ROLL (settle counter discarded); counter=0 -> DONE; otherwise the counter decrements.
REQ-018 DONE: dice hold; valid=1 for exactly this one cycle; roll_count increments, saturating at 255; unconditional -> IDLE.
REQ-019 Advance rule: die i (0-based) SHALL step by i+1, so d' = ((d-1+i+1) mod FACES)+1, with values in 1..FACES only.
REQ-020 Illegal value (d=0 or d>FACES), on any cycle and in any state, SHALL be replaced by 1 on the next edge.
REQ-021 Dice are independent registers; advancing one die SHALL NOT depend on another die's value.
REQ-022 sum SHALL equal the sum of the throw fields in the same cycle, with no truncation; SW bits are sufficient.
REQ-023 Total advances per roll SHALL equal (ROLL cycles) + SETTLE_CYC.
REQ-024 btn_s held high through DONE: the FSM passes through IDLE for one cycle, then enters ROLL; DONE is never skipped.
REQ-025 throw, sum and valid SHALL be stable and mutually consistent in the DONE cycle.

Reset
REQ-026 rst=0 SHALL force: every die = 1, sum = N_DICE, valid=0, rolling=0, roll_count=0, FSM=IDLE, synchroniser flops=0, settle counter=0.
REQ-027 Reset asserted mid-ROLL or mid-SETTLE SHALL abort the roll with no valid pulse and no roll_count increment.
REQ-028 After rst deasserts, the first state change SHALL occur no earlier than the second rising clk edge, set by synchroniser latency.

Verification (defaults: N_DICE=2, FACES=6, SETTLE_CYC=4)
REQ-029 Reset check: pulse rst low -> throw={1,1}, sum=2, valid=0, roll_count=0.
REQ-030 Basic roll: btn_s high for 3 ROLL cycles, then released -> 7 advances; die0=2, die1=3, sum=5; valid pulses once; roll_count=1.
REQ-031 Wrap-around: force die0=6 and die1=5, then 1 advance -> die0=1, die1=1. Force die1=6, then 1 advance -> die1=2.
REQ-032 Re-press during SETTLE: release, then raise again after 2 SETTLE cycles -> FSM returns to ROLL, no valid pulse; valid appears only after a full 4-cycle SETTLE.
REQ-033 Illegal-value recovery and reset mid-roll: force die1=0 -> die1=1 on the next edge. Drive rst low during ROLL -> immediate reset values, no valid pulse.
REQ-034 Saturation: 260 complete rolls -> roll_count=255, and valid still pulses on every roll.
